// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Detects hazards that forwarding cannot resolve: load-use, and register
//   dependencies on the multi-cycle mul/div unit. A pending-write scoreboard
//   and a latency counter track the single in-flight mul/div op.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rs1Addr_id/rs2Addr_id     ID source addresses; rs1Use_id/rs2Use_id mark use
//   rdAddr_id, RegWrite_id    ID destination and write enable
//   md_id                     ID instruction is a mul/div op
//   MemRead_ex, rdAddr_ex     EX load indicator and destination
//   flush_ex                  taken branch in EX; kills the ID instruction
//   stall, bubble_id_ex       pipeline hold / ID-EX NOP insertion
//   md_issue, md_busy         mul/div accept and occupancy
//   md_done, md_rdAddr        one-cycle writeback pulse and its destination
//   pending                   outstanding mul/div write per register
module hazard_scoreboard #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned NREG   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      rs1Addr_id,
  input  logic [3:0]      rs2Addr_id,
  input  logic            rs1Use_id,
  input  logic            rs2Use_id,
  input  logic [3:0]      rdAddr_id,
  input  logic            RegWrite_id,
  input  logic            md_id,
  input  logic            MemRead_ex,
  input  logic [3:0]      rdAddr_ex,
  input  logic            flush_ex,
  output logic            stall,
  output logic            bubble_id_ex,
  output logic            md_issue,
  output logic            md_busy,
  output logic            md_done,
  output logic [3:0]      md_rdAddr,
  output logic [NREG-1:0] pending
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [3:0]      rd_nxt;
  logic [NREG-1:0] pend_nxt;
  logic            done_nxt;

  logic [NREG-1:0] eff_pending;
  logic            load_use, raw, waw, struct_hz, hz;

  // A result completing this cycle is written before the register file is
  // read, so it no longer blocks dependents.
  always_comb begin
    eff_pending = pending;
    if (md_done) eff_pending[md_rdAddr] = 1'b0;
  end

  always_comb begin
    load_use  = MemRead_ex && (rdAddr_ex != 4'd0) &&
                ((rs1Use_id && (rs1Addr_id == rdAddr_ex)) ||
                 (rs2Use_id && (rs2Addr_id == rdAddr_ex)));
    raw       = (rs1Use_id && eff_pending[rs1Addr_id]) ||
                (rs2Use_id && eff_pending[rs2Addr_id]);
    waw       = RegWrite_id && eff_pending[rdAddr_id];
    struct_hz = md_id && md_busy && !md_done;
    hz        = load_use || raw || waw || struct_hz;
    stall        = hz && !flush_ex;
    bubble_id_ex = hz || flush_ex;
    md_issue     = md_id && !hz && !flush_ex;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      md_rdAddr <= '0;
      pending   <= '0;
      md_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      md_rdAddr <= rd_nxt;
      pending   <= pend_nxt;
      md_done   <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = md_rdAddr;
    pend_nxt  = pending;
    case (state)
      IDLE: begin
        if (md_issue) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(MD_LAT - 1);
        end
      end
      BUSY: begin
        if (md_done) begin
          if (md_issue) cnt_nxt = 4'(MD_LAT - 1);
          else          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Clear before set so a same-register back-to-back issue keeps its bit.
    if (md_done) pend_nxt[md_rdAddr] = 1'b0;
    if (md_issue) begin
      rd_nxt = rdAddr_id;
      if (RegWrite_id && (rdAddr_id != 4'd0)) pend_nxt[rdAddr_id] = 1'b1;
    end
    // md_done is registered: it rises in the cycle the counter reads zero.
    done_nxt = (state_nxt == BUSY) && (cnt_nxt == 4'd0);
  end

  // Outputs
  always_comb begin
    md_busy = (state == BUSY);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed-vector bench for hazard_scoreboard with MD_LAT=4. Inputs change
//   1 ns after the rising edge; outputs are sampled 2 ns later.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rs1Addr_id, rs2Addr_id, rdAddr_id, rdAddr_ex;
  logic        rs1Use_id, rs2Use_id, RegWrite_id, md_id, MemRead_ex, flush_ex;
  logic        stall, bubble_id_ex, md_issue, md_busy, md_done;
  logic [3:0]  md_rdAddr;
  logic [15:0] pending;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard #(.MD_LAT(4), .NREG(16)) dut (
    .clk(clk), .rst(rst),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1Use_id(rs1Use_id), .rs2Use_id(rs2Use_id),
    .rdAddr_id(rdAddr_id), .RegWrite_id(RegWrite_id), .md_id(md_id),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex), .flush_ex(flush_ex),
    .stall(stall), .bubble_id_ex(bubble_id_ex), .md_issue(md_issue),
    .md_busy(md_busy), .md_done(md_done), .md_rdAddr(md_rdAddr),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    rs1Addr_id = '0; rs2Addr_id = '0; rdAddr_id = '0; rdAddr_ex = '0;
    rs1Use_id = 1'b0; rs2Use_id = 1'b0; RegWrite_id = 1'b0; md_id = 1'b0;
    MemRead_ex = 1'b0; flush_ex = 1'b0;
  endtask

  task automatic issue_md(input logic [3:0] rd);
    idle_in();
    md_id = 1'b1; RegWrite_id = 1'b1; rdAddr_id = rd;
  endtask

  // Drives the stall-controls trio check in one call.
  task automatic check_ctl(input string tag, input logic s, input logic b, input logic i);
    check({tag, ".stall"},  {15'd0, stall}, {15'd0, s});
    check({tag, ".bubble"}, {15'd0, bubble_id_ex}, {15'd0, b});
    check({tag, ".issue"},  {15'd0, md_issue}, {15'd0, i});
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    tick(); tick();
    settle();
    check("rst.pending", pending, 16'h0000);
    check("rst.busy", {15'd0, md_busy}, 16'd0);
    check("rst.done", {15'd0, md_done}, 16'd0);
    check("rst.rd", {12'd0, md_rdAddr}, 16'd0);
    check_ctl("rst", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Load-use
    MemRead_ex = 1'b1; rdAddr_ex = 4'd5; rs1Addr_id = 4'd5; rs1Use_id = 1'b1;
    settle();
    check_ctl("lu.rs1", 1'b1, 1'b1, 1'b0);
    rs1Use_id = 1'b0; rs2Use_id = 1'b1; rs2Addr_id = 4'd5; settle();
    check_ctl("lu.rs2", 1'b1, 1'b1, 1'b0);
    rdAddr_ex = 4'd0; rs1Addr_id = 4'd0; rs2Addr_id = 4'd0; settle();
    check_ctl("lu.r0", 1'b0, 1'b0, 1'b0);
    rdAddr_ex = 4'd5; rs2Use_id = 1'b0; settle();
    check_ctl("lu.nouse", 1'b0, 1'b0, 1'b0);
    tick();

    // RAW on mul/div result, rd=7
    issue_md(4'd7); settle();
    check_ctl("raw.c0", 1'b0, 1'b0, 1'b1);
    tick();
    idle_in(); rs2Use_id = 1'b1; rs2Addr_id = 4'd7;
    for (int c = 1; c <= 3; c++) begin
      settle();
      check("raw.pending", pending, 16'h0080);
      check("raw.busy", {15'd0, md_busy}, 16'd1);
      check("raw.done_lo", {15'd0, md_done}, 16'd0);
      check_ctl("raw.stall", 1'b1, 1'b1, 1'b0);
      tick();
    end
    settle();
    check("raw.c4.done", {15'd0, md_done}, 16'd1);
    check("raw.c4.rd", {12'd0, md_rdAddr}, 16'd7);
    check_ctl("raw.c4", 1'b0, 1'b0, 1'b0);
    tick(); idle_in(); settle();
    check("raw.c5.pending", pending, 16'h0000);
    check("raw.c5.done", {15'd0, md_done}, 16'd0);
    check("raw.c5.busy", {15'd0, md_busy}, 16'd0);
    tick();

    // Structural / back-to-back: rd=3 then rd=4
    issue_md(4'd3); settle();
    check_ctl("b2b.c0", 1'b0, 1'b0, 1'b1);
    tick();
    issue_md(4'd4);
    for (int c = 1; c <= 3; c++) begin
      settle();
      check("b2b.pending3", pending, 16'h0008);
      check_ctl("b2b.struct", 1'b1, 1'b1, 1'b0);
      tick();
    end
    settle();
    check("b2b.c4.done", {15'd0, md_done}, 16'd1);
    check("b2b.c4.rd", {12'd0, md_rdAddr}, 16'd3);
    check_ctl("b2b.c4", 1'b0, 1'b0, 1'b1);
    tick(); idle_in(); settle();
    check("b2b.c5.pending", pending, 16'h0010);
    check("b2b.c5.busy", {15'd0, md_busy}, 16'd1);
    check("b2b.c5.done", {15'd0, md_done}, 16'd0);
    tick(); settle();
    check("b2b.c6.done", {15'd0, md_done}, 16'd0);
    tick(); settle();
    check("b2b.c7.done", {15'd0, md_done}, 16'd0);
    tick(); settle();
    check("b2b.c8.done", {15'd0, md_done}, 16'd1);
    check("b2b.c8.rd", {12'd0, md_rdAddr}, 16'd4);
    tick(); settle();
    check("b2b.c9.pending", pending, 16'h0000);
    check("b2b.c9.busy", {15'd0, md_busy}, 16'd0);
    tick();

    // WAW on rd=9
    issue_md(4'd9); settle();
    check_ctl("waw.c0", 1'b0, 1'b0, 1'b1);
    tick();
    idle_in(); RegWrite_id = 1'b1; rdAddr_id = 4'd9;
    for (int c = 1; c <= 3; c++) begin
      settle();
      check("waw.pending", pending, 16'h0200);
      check_ctl("waw.stall", 1'b1, 1'b1, 1'b0);
      tick();
    end
    settle();
    check("waw.c4.done", {15'd0, md_done}, 16'd1);
    check_ctl("waw.c4", 1'b0, 1'b0, 1'b0);
    tick(); idle_in(); settle();
    check("waw.c5.pending", pending, 16'h0000);
    tick();

    // Flush priority while rd=6 in flight
    issue_md(4'd6); tick();
    idle_in(); rs1Use_id = 1'b1; rs1Addr_id = 4'd6;
    md_id = 1'b1; RegWrite_id = 1'b1; rdAddr_id = 4'd10; flush_ex = 1'b1;
    settle();
    check_ctl("fl.c1", 1'b0, 1'b1, 1'b0);
    tick(); flush_ex = 1'b0; settle();
    check("fl.c2.pending", pending, 16'h0040);
    check_ctl("fl.c2", 1'b1, 1'b1, 1'b0);
    tick(); idle_in(); flush_ex = 1'b1; settle();
    check_ctl("fl.c3", 1'b0, 1'b1, 1'b0);
    tick(); idle_in(); settle();
    check("fl.c4.done", {15'd0, md_done}, 16'd1);
    check("fl.c4.rd", {12'd0, md_rdAddr}, 16'd6);
    tick(); settle();
    check("fl.c5.pending", pending, 16'h0000);
    tick();

    // Register 0 destination never enters the scoreboard
    issue_md(4'd0); tick();
    idle_in(); rs1Use_id = 1'b1; rs1Addr_id = 4'd0; settle();
    check("r0.pending", pending, 16'h0000);
    check("r0.busy", {15'd0, md_busy}, 16'd1);
    check_ctl("r0", 1'b0, 1'b0, 1'b0);
    idle_in();
    tick(); tick(); tick(); tick();

    // Reset mid-op
    issue_md(4'd2); tick();
    idle_in(); settle();
    check("rm.c1.pending", pending, 16'h0004);
    tick();
    rst = 1'b1; tick(); rst = 1'b0; settle();
    check("rm.pending", pending, 16'h0000);
    check("rm.busy", {15'd0, md_busy}, 16'd0);
    for (int c = 0; c < 6; c++) begin
      check("rm.nodone", {15'd0, md_done}, 16'd0);
      tick(); settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
